// File: rtl/var_delay_line_if.sv
// var_delay_line_if: sample stream, delay programming and delayed-output bundle.
// Ports seen from the delay line (slave): i_en/i_data sample strobe and value,
// i_delay_load/i_delay_in delay programming, o_* delayed sample, strobe, validity, delay.
interface var_delay_line_if #(
  parameter int WIDTH = 16,
  parameter int DW    = 7
);
  logic             i_en;
  logic [WIDTH-1:0] i_data;
  logic             i_delay_load;
  logic [DW-1:0]    i_delay_in;
  logic [DW-1:0]    o_delay_cur;
  logic [WIDTH-1:0] o_data;
  logic             o_stb;
  logic             o_valid;

  // Producer / controller side.
  modport master (
    output i_en, i_data, i_delay_load, i_delay_in,
    input  o_delay_cur, o_data, o_stb, o_valid
  );

  // Delay line side.
  modport slave (
    input  i_en, i_data, i_delay_load, i_delay_in,
    output o_delay_cur, o_data, o_stb, o_valid
  );
endinterface

// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable delay of 1..MAX_DELAY accepted samples (en=1 cycles).
// Latency: output registered, O updates on the clock edge of each strobe; D=1 is a plain register.
// Backpressure: none; every en=1 cycle is accepted. Ports: i_clk, i_rst (sync, active-high), bus.
module var_delay_line #(
  parameter int WIDTH      = 16,
  parameter int MAX_DELAY  = 64,
  parameter int INIT_DELAY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  var_delay_line_if.slave    bus
);
  localparam int DW    = $clog2(MAX_DELAY + 1);
  localparam int DEPTH = MAX_DELAY - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so cnt+1 and wp+DEPTH never overflow; DW >= AW always holds.
  localparam int CW    = DW + 1;

  // Circular buffer, intentionally without reset so it can map to RAM.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wp;
  logic [DW-1:0]    r_cnt;
  logic [DW-1:0]    r_delay;
  logic [WIDTH-1:0] r_o;
  logic             r_stb;
  logic             r_valid;

  logic [DW-1:0]    w_din_clamped;
  logic [DW-1:0]    w_d_eff;
  logic [DW-1:0]    w_cnt_base;
  logic [CW-1:0]    w_cnt_inc;
  logic [DW-1:0]    w_cnt_next;
  logic             w_hit;
  logic [CW-1:0]    w_wp_ext;
  logic [CW-1:0]    w_dm1;
  logic [CW-1:0]    w_rd_ext;
  logic [AW-1:0]    w_rd;
  logic [WIDTH-1:0] w_rd_dat;
  logic [AW-1:0]    w_wp_next;

  // Requested delay forced into 1..MAX_DELAY.
  always_comb begin
    w_din_clamped = bus.i_delay_in;
    if (bus.i_delay_in == '0)
      w_din_clamped = DW'(1);
    else if (bus.i_delay_in > DW'(MAX_DELAY))
      w_din_clamped = DW'(MAX_DELAY);
  end

  // A coinciding load takes effect before the sample: the sample sees the new
  // delay and becomes the first sample of the new fill.
  assign w_d_eff    = bus.i_delay_load ? w_din_clamped : r_delay;
  assign w_cnt_base = bus.i_delay_load ? '0 : r_cnt;
  assign w_cnt_inc  = CW'(w_cnt_base) + CW'(1);
  assign w_cnt_next = (w_cnt_inc > CW'(MAX_DELAY)) ? DW'(MAX_DELAY) : w_cnt_inc[DW-1:0];
  assign w_hit      = (w_cnt_inc >= CW'(w_d_eff));

  // Read address (wp - (D-1)) mod DEPTH without a divider: D-1 is at most
  // DEPTH, so one conditional add of DEPTH is enough. D-1 == DEPTH reads the
  // slot about to be overwritten, which still holds the oldest sample.
  assign w_wp_ext = CW'(r_wp);
  assign w_dm1    = CW'(w_d_eff) - CW'(1);
  assign w_rd_ext = (w_wp_ext >= w_dm1) ? (w_wp_ext - w_dm1)
                                         : (w_wp_ext + CW'(DEPTH) - w_dm1);
  assign w_rd     = w_rd_ext[AW-1:0];

  // D=1 bypasses the buffer and registers the incoming sample directly.
  assign w_rd_dat = (w_d_eff == DW'(1)) ? bus.i_data : r_mem[w_rd];

  assign w_wp_next = (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + AW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst && bus.i_en)
      r_mem[r_wp] <= bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_cnt   <= '0;
      r_delay <= DW'(INIT_DELAY);
      r_o     <= '0;
      r_stb   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_stb <= bus.i_en;
      if (bus.i_delay_load) begin
        r_delay <= w_din_clamped;
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end
      // Strobe assignments come last so they override the load's cnt/valid.
      if (bus.i_en) begin
        r_wp    <= w_wp_next;
        r_cnt   <= w_cnt_next;
        r_valid <= w_hit;
        r_o     <= w_hit ? w_rd_dat : '0;
      end
    end
  end

  assign bus.o_delay_cur = r_delay;
  assign bus.o_data      = r_o;
  assign bus.o_stb       = r_stb;
  assign bus.o_valid     = r_valid;

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: directed checks of two delay lines (MAX_DELAY 64 / INIT 1 and
// MAX_DELAY 50 / INIT 3) covering reset, D=1, load/fill, strobe gating, clamping,
// wrap-around and mid-stream reset.
module tb_var_delay_line;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  var_delay_line_if #(.WIDTH(16), .DW(7)) bus_a ();
  var_delay_line_if #(.WIDTH(16), .DW(6)) bus_b ();

  var_delay_line #(.WIDTH(16), .MAX_DELAY(64), .INIT_DELAY(1)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  var_delay_line #(.WIDTH(16), .MAX_DELAY(50), .INIT_DELAY(3)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one clock of inputs on DUT a (sel=0) or b (sel=1); returns 1ns after the edge.
  task automatic step(input bit sel, input logic rst, input logic en, input logic [15:0] d,
                      input logic ld, input logic [6:0] din);
    @(negedge clk);
    if (!sel) begin
      rst_a = rst; bus_a.i_en = en; bus_a.i_data = d;
      bus_a.i_delay_load = ld; bus_a.i_delay_in = din;
    end else begin
      rst_b = rst; bus_b.i_en = en; bus_b.i_data = d;
      bus_b.i_delay_load = ld; bus_b.i_delay_in = din[5:0];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_d;
    logic        exp_v;
    int          s;

    bus_a.i_en = 1'b0; bus_a.i_data = '0; bus_a.i_delay_load = 1'b0; bus_a.i_delay_in = '0;
    bus_b.i_en = 1'b0; bus_b.i_data = '0; bus_b.i_delay_load = 1'b0; bus_b.i_delay_in = '0;

    // ---------------- DUT a: MAX_DELAY=64, INIT_DELAY=1 ----------------
    step(0, 1, 1, 16'd55, 0, 0);
    step(0, 1, 1, 16'd56, 0, 0);
    chk("a_rst_o",     32'(bus_a.o_data), 0);
    chk("a_rst_stb",   32'(bus_a.o_stb), 0);
    chk("a_rst_valid", 32'(bus_a.o_valid), 0);
    chk("a_rst_dcur",  32'(bus_a.o_delay_cur), 1);

    // D=1: registered copy, valid from the first strobe.
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1, 16'(k), 0, 0);
      chk("a_d1_o", 32'(bus_a.o_data), 32'(k));
      chk("a_d1_valid", 32'(bus_a.o_valid), 1);
      chk("a_d1_stb", 32'(bus_a.o_stb), 1);
    end
    step(0, 0, 0, 16'd99, 0, 0);
    chk("a_idle_stb", 32'(bus_a.o_stb), 0);
    chk("a_idle_hold", 32'(bus_a.o_data), 5);

    // Load 5 without a strobe: O held, validity dropped.
    step(0, 0, 0, 16'd0, 1, 7'd5);
    chk("a_ld5_dcur", 32'(bus_a.o_delay_cur), 5);
    chk("a_ld5_valid", 32'(bus_a.o_valid), 0);
    chk("a_ld5_hold", 32'(bus_a.o_data), 5);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 16'(100 + k), 0, 0);
      chk("a_d5_o", 32'(bus_a.o_data), (k >= 4) ? 32'(100 + k - 4) : 0);
      chk("a_d5_valid", 32'(bus_a.o_valid), (k >= 4) ? 1 : 0);
    end

    // Reload same value, then strobe every other clock: delay counts strobes.
    step(0, 0, 0, 16'd0, 1, 7'd5);
    chk("a_reld_valid", 32'(bus_a.o_valid), 0);
    chk("a_reld_hold", 32'(bus_a.o_data), 103);
    exp_d = 16'd103; exp_v = 1'b0; s = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, ((i % 2) == 0), 16'(300 + i), 0, 0);
      if ((i % 2) == 0) begin
        s++;
        if (s >= 5) begin exp_d = 16'(300 + 2 * (s - 5)); exp_v = 1'b1; end
        else        begin exp_d = 16'd0; exp_v = 1'b0; end
      end
      chk("a_tog_stb", 32'(bus_a.o_stb), ((i % 2) == 0) ? 1 : 0);
      chk("a_tog_o", 32'(bus_a.o_data), 32'(exp_d));
      chk("a_tog_valid", 32'(bus_a.o_valid), 32'(exp_v));
    end

    // Load of 0 coinciding with a strobe: clamps to 1, valid on the same edge.
    step(0, 0, 1, 16'd777, 1, 7'd0);
    chk("a_ld0_dcur", 32'(bus_a.o_delay_cur), 1);
    chk("a_ld0_o", 32'(bus_a.o_data), 777);
    chk("a_ld0_valid", 32'(bus_a.o_valid), 1);

    // Load MAX_DELAY+3 clamps to 64; stream across several buffer wraps.
    step(0, 0, 0, 16'd0, 1, 7'd67);
    chk("a_ldmax_dcur", 32'(bus_a.o_delay_cur), 64);
    chk("a_ldmax_valid", 32'(bus_a.o_valid), 0);
    for (int k = 0; k < 200; k++) begin
      step(0, 0, 1, 16'(1000 + k), 0, 0);
      chk("a_d64_o", 32'(bus_a.o_data), (k >= 63) ? 32'(1000 + k - 63) : 0);
      chk("a_d64_valid", 32'(bus_a.o_valid), (k >= 63) ? 1 : 0);
    end
    step(0, 0, 0, 16'd0, 0, 0);

    // ---------------- DUT b: MAX_DELAY=50, INIT_DELAY=3 ----------------
    step(1, 1, 0, 16'd0, 0, 0);
    chk("b_rst_o", 32'(bus_b.o_data), 0);
    chk("b_rst_valid", 32'(bus_b.o_valid), 0);
    chk("b_rst_dcur", 32'(bus_b.o_delay_cur), 3);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 1, 16'(10 + k), 0, 0);
      chk("b_d3_o", 32'(bus_b.o_data), (k >= 2) ? 32'(10 + k - 2) : 0);
      chk("b_d3_valid", 32'(bus_b.o_valid), (k >= 2) ? 1 : 0);
    end

    // Full depth on a non-power-of-two buffer.
    step(1, 0, 0, 16'd0, 1, 7'd50);
    chk("b_ld50_dcur", 32'(bus_b.o_delay_cur), 50);
    for (int k = 0; k < 160; k++) begin
      step(1, 0, 1, 16'(2000 + k), 0, 0);
      chk("b_d50_o", 32'(bus_b.o_data), (k >= 49) ? 32'(2000 + k - 49) : 0);
      chk("b_d50_valid", 32'(bus_b.o_valid), (k >= 49) ? 1 : 0);
    end

    // D=8 stream, then reset mid-stream (with a competing load and strobe).
    step(1, 0, 0, 16'd0, 1, 7'd8);
    chk("b_ld8_dcur", 32'(bus_b.o_delay_cur), 8);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 1, 16'(3000 + k), 0, 0);
      chk("b_d8_o", 32'(bus_b.o_data), (k >= 7) ? 32'(3000 + k - 7) : 0);
    end
    step(1, 1, 1, 16'd9999, 1, 7'd10);
    chk("b_mrst_o", 32'(bus_b.o_data), 0);
    chk("b_mrst_stb", 32'(bus_b.o_stb), 0);
    chk("b_mrst_valid", 32'(bus_b.o_valid), 0);
    chk("b_mrst_dcur", 32'(bus_b.o_delay_cur), 3);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 16'(4000 + k), 0, 0);
      chk("b_post_o", 32'(bus_b.o_data), (k >= 2) ? 32'(4000 + k - 2) : 0);
      chk("b_post_valid", 32'(bus_b.o_valid), (k >= 2) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
